// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   CHAR_CR / CHAR_LF : control characters used by the optional CRLF expansion
//   UART_BUF_DEPTH    : default FIFO depth for uart_tx_buffer
//   byte_t            : one UART character
//   crlf_state_t      : state of the LF -> CR,LF expander
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t CHAR_CR        = 8'h0D;
    localparam byte_t CHAR_LF        = 8'h0A;
    localparam int    UART_BUF_DEPTH = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        CR_DONE = 1'b1
    } crlf_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for uart_tx_buffer: DEPTH x 8 bits, one synchronous write
// port and one asynchronous (combinational) read port. No reset; contents
// are undefined until written.
// Ports:
//   i_clk   : clock, rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, combinational from i_raddr
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_BUF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  byte_t             i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output byte_t             o_rdata
);

    byte_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO between the core's UART write port (producer, wr_*) and the
// UART serializer (consumer, out_*). Lets the core burst writes while the
// serializer drains one byte per frame.
//
// Build option: define UART_CRLF_EN to expand every LF from the core into
// CR followed by LF. Without it every byte is queued verbatim.
//
// Ports:
//   CLK              : clock, rising edge
//   RST_N            : asynchronous active-low reset
//   wr_valid/wr_data : byte offered by the core
//   wr_ready         : byte accepted on a cycle with wr_valid & wr_ready
//   out_valid        : head byte present (level != 0)
//   out_data         : head byte, show-ahead
//   out_ready        : serializer takes the head on out_valid & out_ready
//   level            : current occupancy 0..DEPTH
//   hwm              : highest occupancy seen since reset
//   o_dbg_crlf_state : expander state (constant IDLE without UART_CRLF_EN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until accepted; the
// consumer may drop ready at any time. out_* come only from registered
// state, so a written byte is visible the cycle after the write edge.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_BUF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_valid,
    input  byte_t             wr_data,
    output logic              wr_ready,
    output logic              out_valid,
    output byte_t             out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   hwm,
    output crlf_state_t       o_dbg_crlf_state
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ZERO = '0;
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [ADDR_W:0]   r_hwm;
    logic [ADDR_W:0]   w_level_nxt;
    logic [ADDR_W:0]   w_hwm_nxt;
    logic              w_not_full;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_ready;
    byte_t             w_push_data;

    // Room is judged on the registered level only, so a pop in the same
    // cycle never frees a slot for a push until the next cycle.
    assign w_not_full = (r_level != LVL_FULL);
    assign w_pop      = (r_level != LVL_ZERO) && out_ready;

`ifdef UART_CRLF_EN
    crlf_state_t r_state;
    crlf_state_t w_state_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An LF seen in IDLE is not accepted: a CR is queued in its place and
    // the core keeps holding the LF, which is accepted from CR_DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        w_push      = 1'b0;
        w_push_data = wr_data;
        case (r_state)
            IDLE: begin
                if (wr_valid && (wr_data == CHAR_LF) && w_not_full) begin
                    w_push      = 1'b1;
                    w_push_data = CHAR_CR;
                    w_state_nxt = CR_DONE;
                end else begin
                    w_wr_ready = w_not_full;
                    w_push     = wr_valid && w_not_full;
                end
            end
            CR_DONE: begin
                w_wr_ready = w_not_full;
                w_push     = wr_valid && w_not_full;
                if (w_push) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (!RST_N) begin
            w_wr_ready = 1'b0;
            w_push     = 1'b0;
        end
    end

    assign o_dbg_crlf_state = r_state;
`else
    always_comb begin
        w_wr_ready  = w_not_full && RST_N;
        w_push      = wr_valid && w_wr_ready;
        w_push_data = wr_data;
    end

    assign o_dbg_crlf_state = IDLE;
`endif

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
        w_hwm_nxt = (w_level_nxt > r_hwm) ? w_level_nxt : r_hwm;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hwm    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
            r_hwm   <= w_hwm_nxt;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_push_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (out_data)
    );

    assign wr_ready  = w_wr_ready;
    assign out_valid = (r_level != LVL_ZERO);
    assign level     = r_level;
    assign hwm       = r_hwm;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer (DEPTH=16). Inputs change 1ns after the
// rising edge; outputs are checked at that point, once they have settled.
// The CRLF scenarios are compiled in when UART_CRLF_EN is defined.
module tb_uart_tx_buffer;
    import uart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [4:0]  level;
    logic [4:0]  hwm;
    crlf_state_t dbg_state;

    int n_checks;
    int n_errors;
    logic [7:0] exp_q[$];

    uart_tx_buffer #(.DEPTH(16)) dut (
        .CLK              (clk),
        .RST_N            (rst_n),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .level            (level),
        .hwm              (hwm),
        .o_dbg_crlf_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until accepted (bounded wait).
    task automatic push_byte(input logic [7:0] b);
        int n;
        wr_valid = 1'b1;
        wr_data  = b;
        n = 0;
        while (!wr_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("push_timeout", 32'd1, 32'd0);
        step();
        wr_valid = 1'b0;
        exp_q.push_back(b);
    endtask

    // Take one byte and compare with the scoreboard head.
    task automatic pop_check(input string tag);
        logic [7:0] e;
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("pop_timeout", 32'd1, 32'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check(tag, {24'd0, out_data}, {24'd0, e});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        out_ready = 1'b0;

        // 1: reset then idle
        #2;
        check("wr_ready_in_reset", {31'd0, wr_ready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_hwm", {27'd0, hwm}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
        step();
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // 2: three bytes, then drain in order
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        check("t2_level", {27'd0, level}, 32'd3);
        check("t2_head", {24'd0, out_data}, 32'h41);
        check("t2_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) pop_check("t2_drain");
        check("t2_level_empty", {27'd0, level}, 32'd0);
        check("t2_hwm", {27'd0, hwm}, 32'd3);

        // 3: fill to DEPTH, 17th stalls until a pop has taken effect
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        check("t3_level_full", {27'd0, level}, 32'd16);
        check("t3_hwm_full", {27'd0, hwm}, 32'd16);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        #0;
        check("t3_stall", {31'd0, wr_ready}, 32'd0);
        step();
        check("t3_stall_hold", {31'd0, wr_ready}, 32'd0);
        check("t3_level_hold", {27'd0, level}, 32'd16);
        check("t3_pop_head", {24'd0, out_data}, 32'h10);
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        #0;
        check("t3_no_room_same_cycle", {31'd0, wr_ready}, 32'd0);
        step();
        out_ready = 1'b0;
        #0;
        check("t3_level_after_pop", {27'd0, level}, 32'd15);
        check("t3_ready_after_pop", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        exp_q.push_back(8'hEE);
        check("t3_level_refill", {27'd0, level}, 32'd16);
        for (int i = 0; i < 16; i++) pop_check("t3_drain");
        check("t3_empty", {31'd0, out_valid}, 32'd0);

        // 4: steady push+pop at level 8 for 40 cycles, pointers wrap
        for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
        for (int i = 0; i < 40; i++) begin
            wr_valid  = 1'b1;
            wr_data   = 8'h80 + 8'(i);
            out_ready = 1'b1;
            #0;
            check("t4_ready", {31'd0, wr_ready}, 32'd1);
            check("t4_order", {24'd0, out_data}, {24'd0, exp_q[0]});
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(8'h80 + 8'(i));
            check("t4_level", {27'd0, level}, 32'd8);
        end
        wr_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) pop_check("t4_drain");

`ifdef UART_CRLF_EN
        // 5a: LF from empty expands to CR, LF
        wr_valid = 1'b1;
        wr_data  = CHAR_LF;
        #0;
        check("t5_lf_ready_low", {31'd0, wr_ready}, 32'd0);
        step();
        check("t5_state_cr_done", {31'd0, dbg_state}, {31'd0, CR_DONE});
        check("t5_lf_ready_high", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        check("t5_state_idle", {31'd0, dbg_state}, {31'd0, IDLE});
        check("t5_level2", {27'd0, level}, 32'd2);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        pop_check("t5_cr");
        pop_check("t5_lf");

        // 5b: LF at level 15, the CR fills the FIFO
        for (int i = 0; i < 15; i++) push_byte(8'h50 + 8'(i));
        wr_valid = 1'b1;
        wr_data  = CHAR_LF;
        step();
        check("t5b_level_full", {27'd0, level}, 32'd16);
        check("t5b_lf_blocked", {31'd0, wr_ready}, 32'd0);
        step();
        check("t5b_lf_still_blocked", {31'd0, wr_ready}, 32'd0);
        check("t5b_head", {24'd0, out_data}, 32'h50);
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5b_lf_ready", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        check("t5b_level", {27'd0, level}, 32'd16);
        for (int i = 0; i < 16; i++) pop_check("t5b_drain");
`endif

        // 6: reset mid-drain at level 5
        for (int i = 0; i < 7; i++) push_byte(8'hA0 + 8'(i));
        pop_check("t6_pop");
        pop_check("t6_pop");
        check("t6_level5", {27'd0, level}, 32'd5);
`ifdef UART_CRLF_EN
        wr_valid = 1'b1;
        wr_data  = CHAR_LF;
        step();
        check("t6_in_cr_done", {31'd0, dbg_state}, {31'd0, CR_DONE});
`endif
        rst_n = 1'b0;
        #1;
        check("t6_level_zero", {27'd0, level}, 32'd0);
        check("t6_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_wr_ready", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        check("t6_hwm_zero", {27'd0, hwm}, 32'd0);
        check("t6_state_idle", {31'd0, dbg_state}, {31'd0, IDLE});
        check("t6_ready_after", {31'd0, wr_ready}, 32'd1);

        // Quick sanity after reset: FIFO works again from pointer 0.
        push_byte(8'h5A);
        check("t6_post_level", {27'd0, level}, 32'd1);
        pop_check("t6_post_data");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: stop the run if something stalls unexpectedly.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
